register_file_master: RTL
=========================

# register_file_master

Clocked initiator for the asynchronous register-file bus: chip select (active-low), output enable, write strobe, address and bidirectional data. It accepts single read/write requests from synchronous logic over a valid/ready handshake and sequences the bus phases with programmable setup, strobe and access times. For reads it returns captured data over a one-cycle response pulse. It is the master end of the bus whose responder writes on the rising edge of the write strobe and drives data while selected with output enable high.

## Interface
- `Width`, 8: data bus width.
- `Depth`, 5: address width; the bus addresses 2**Depth locations.
- `SETUP_CYCLES`, 1: cycles that address and write data are stable before `ws_o` rises. Must be ≥1.
- `STROBE_CYCLES`, 1: cycles `ws_o` is held high. Must be ≥1.
- `READ_WAIT`, 2: cycles `oe_o` is high before read data is sampled. Must be ≥1.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted when `req_valid_i` and `req_ready_o` are both high at a rising edge.
- `req_write_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  Depth  request address.
- `req_wdata_i`  in  Width  write data.
- `rsp_valid_o`  out  1  one-cycle completion pulse, for both reads and writes.
- `rsp_rdata_o`  out  Width  read data; updated only by reads.
- `cs_no`  out  1  bus chip select, active-low.
- `oe_o`  out  1  bus output enable; high means the responder drives data.
- `ws_o`  out  1  bus write strobe; the responder writes on its rising edge.
- `address_o`  out  Depth  bus address.
- `data_io`  inout  Width  bus data; high-Z whenever this block is not driving.

## Operation
- All bus outputs are registered. `data_io` is driven from a registered output-enable, only in the W_SETUP, W_STROBE and W_HOLD states.
- At accept, address, data and direction are captured into internal registers. Request inputs are ignored while busy.
- States and transitions:
  - IDLE: `cs_no`=1, `oe_o`=0, `ws_o`=0, `data_io`=Z, `req_ready_o`=1. On accept, go to W_SETUP (write) or R_ACCESS (read).
  - W_SETUP: `cs_no`=0, `oe_o`=0, `ws_o`=0, address and data driven. Lasts `SETUP_CYCLES`, then go to W_STROBE.
  - W_STROBE: as W_SETUP but `ws_o`=1. Lasts `STROBE_CYCLES`, then go to W_HOLD.
  - W_HOLD: `ws_o`=0; `cs_no`, address and data are still held. Lasts 1 cycle, then go to IDLE and set `rsp_valid_o`=1 for that first IDLE cycle.
  - R_ACCESS: `cs_no`=0, `oe_o`=1, `data_io`=Z, address driven. Lasts `READ_WAIT` cycles. On the edge leaving this state, `rsp_rdata_o` <= `data_io` and `rsp_valid_o` <= 1.
  - R_TURN: `cs_no`=1, `oe_o`=0, `data_io`=Z. This is a mandatory turnaround cycle. Lasts 1 cycle, then go to IDLE.
- Bus contention rule: this block never drives `data_io` in any cycle where `oe_o`=1, nor in the cycle immediately after `oe_o`=1.
- A single down-counter, sized for the maximum parameter value, times the multi-cycle states. It reloads on each state entry.
- `req_ready_o` is high only in IDLE. This includes the IDLE cycle in which a write's `rsp_valid_o` is asserted, so back-to-back accept is legal there.
- Address wrap: the address is used as-is. Address 2**Depth−1 is legal and there is no increment logic.

## Timing
- Reset values, applied immediately while `rst_i` is high:
  - `cs_no`=1, `oe_o`=0, `ws_o`=0, `address_o`=0, `data_io`=Z.
  - `req_ready_o`=0, `rsp_valid_o`=0, `rsp_rdata_o`=0.
  - State = IDLE.
  - `req_ready_o` rises on the first clock edge after `rst_i` is released.
- Reset mid-operation: the in-flight request is dropped with no `rsp_valid_o`. If `ws_o` was high, it falls without a write being counted by this block.
- Write occupancy is `SETUP_CYCLES+STROBE_CYCLES+1` cycles from accept edge to IDLE. `rsp_valid_o` is high in the first IDLE cycle.
- Read occupancy is `READ_WAIT+1` cycles from accept edge to IDLE. `rsp_valid_o` and the new `rsp_rdata_o` appear in the R_TURN cycle, which is `READ_WAIT` cycles after the accept edge.
- With default parameters, both write and read take 3 cycles from accept to ready.
- `address_o` is stable from entry to W_SETUP or R_ACCESS until leaving W_HOLD or R_ACCESS. It holds its last value in IDLE.

## Test plan
Benches use a behavioural responder with Width=8 and Depth=5.
- Reset: assert `rst_i` while `ws_o`=1 -> in the same cycle `cs_no`=1, `ws_o`=0, `data_io`=Z, and no `rsp_valid_o`. After release, `req_ready_o`=1 after one edge.
- Write 0xA5 to address 3, then read address 3 (default parameters):
  - `ws_o` is high for exactly 1 cycle.
  - The write response pulse comes 3 cycles after accept.
  - On the read, `rsp_rdata_o`=0xA5 with `rsp_valid_o` 2 cycles after the read accept.
- Boundary addresses: write 0x11 to address 0 and 0x22 to address 31, then read both -> 0x11 and 0x22. `rsp_valid_o` pulses exactly 4 times in total.
- Back-to-back traffic: hold `req_valid_i` high through the sequence write/read/write/read:
  - Each request is accepted only when `req_ready_o`=1.
  - Inputs changed while busy have no effect.
  - `data_io` never resolves to X.
  - An R_TURN cycle is always present between a read and the next write.
- Parameter variant: `SETUP_CYCLES`=2, `STROBE_CYCLES`=3, `READ_WAIT`=4:
  - `ws_o` is high for exactly 3 cycles, preceded by 2 setup cycles.
  - The write response comes 6 cycles after accept.
  - The read response comes 4 cycles after accept, with correct data.

Source files
------------

// File: rtl/register_file_master.sv
// register_file_master: clocked initiator for the asynchronous register-file bus.
// Accepts single read/write requests over valid/ready and sequences chip select,
// output enable, write strobe, address and bidirectional data with programmable
// setup, strobe and read-access times. Reads return data on a one-cycle pulse.
module register_file_master #(
  parameter int unsigned Width         = 8,
  parameter int unsigned Depth         = 5,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned READ_WAIT     = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [Depth-1:0] req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             cs_no,
  output logic             oe_o,
  output logic             ws_o,
  output logic [Depth-1:0] address_o,
  inout  wire  [Width-1:0] data_io
);

  // One down-counter covers the longest timed phase.
  localparam int unsigned MaxSw     = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned MaxCycles = (MaxSw > READ_WAIT) ? MaxSw : READ_WAIT;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] SetupLoad  = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLoad = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] ReadLoad   = CntW'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_SETUP,
    ST_W_STROBE,
    ST_W_HOLD,
    ST_R_ACCESS,
    ST_R_TURN
  } state_t;

  state_t           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [Width-1:0] wdata_q;
  logic             drive_q;

  // Data bus is driven only from the registered enable, set for the write phases.
  assign data_io = drive_q ? wdata_q : {Width{1'bz}};

  // Sequencer: state, phase counter and every registered bus/handshake output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      cs_no       <= 1'b1;
      oe_o        <= 1'b0;
      ws_o        <= 1'b0;
      address_o   <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          cs_no       <= 1'b1;
          oe_o        <= 1'b0;
          ws_o        <= 1'b0;
          drive_q     <= 1'b0;
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            address_o   <= req_addr_i;
            cs_no       <= 1'b0;
            if (req_write_i) begin
              wdata_q <= req_wdata_i;
              drive_q <= 1'b1;
              cnt_q   <= SetupLoad;
              state_q <= ST_W_SETUP;
            end else begin
              oe_o    <= 1'b1;
              cnt_q   <= ReadLoad;
              state_q <= ST_R_ACCESS;
            end
          end
        end

        ST_W_SETUP: begin
          if (cnt_q == '0) begin
            ws_o    <= 1'b1;
            cnt_q   <= StrobeLoad;
            state_q <= ST_W_STROBE;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        ST_W_STROBE: begin
          if (cnt_q == '0) begin
            ws_o    <= 1'b0;
            state_q <= ST_W_HOLD;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        // Hold address/data one cycle past the strobe's falling edge.
        ST_W_HOLD: begin
          cs_no       <= 1'b1;
          drive_q     <= 1'b0;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b1;
          state_q     <= ST_IDLE;
        end

        ST_R_ACCESS: begin
          if (cnt_q == '0) begin
            rsp_rdata_o <= data_io;
            rsp_valid_o <= 1'b1;
            oe_o        <= 1'b0;
            cs_no       <= 1'b1;
            state_q     <= ST_R_TURN;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        // Turnaround: responder releases the bus before any write can start.
        ST_R_TURN: begin
          req_ready_o <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
